// File: rtl/switch_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// Defaults target a 50 MHz clock with a 1 ms tick and a 10 ms settle window.
package switch_pkg;

    localparam int SW_WIDTH        = 8;
    localparam int SW_TICK_DIV     = 50000;
    localparam int SW_STABLE_TICKS = 10;

    // Commit decision made by a bit filter in a given cycle.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // Counter width for a tick count of 0..ticks-1; never narrower than one bit.
    function automatic int cntWidth(input int ticks);
        int w;
        w = $clog2(ticks);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/switch_debouncer_bit.sv
// One switch bit: two-flop synchroniser, tick-driven persistence counter,
// committed level and registered rise/fall strobes.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cntWidth(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             fall_q;
    edge_e            kind_d;

    // A bounce back to the committed level restarts the window; the count
    // only advances on ticks while the synchronised level differs.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        kind_d   = EDGE_NONE;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                cnt_d    = '0;
                kind_d   = s2_q ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= (kind_d == EDGE_RISE);
            fall_q   <= (kind_d == EDGE_FALL);
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounced slide-switch bus for the HPS switch PIO: shared tick prescaler,
// one filter per bit, and a sticky change flag for polling or interrupts.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int TICK_DIV     = SW_TICK_DIV,
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed,
    input  logic             changed_clr
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;
    logic             changed_q;
    logic             changed_d;

    // Tick fires on the last prescaler count; a fresh commit beats a clear.
    always_comb begin
        tick      = (div_q == DIV_LAST);
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        changed_d = changed_q;
        if ((|sw_rise) || (|sw_fall)) begin
            changed_d = 1'b1;
        end else if (changed_clr) begin
            changed_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            div_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk_clk    (clk_clk),
            .reset_reset(reset_reset),
            .tick       (tick),
            .raw        (sw_raw[i]),
            .stable     (sw_stable[i]),
            .rise       (sw_rise[i]),
            .fall       (sw_fall[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with a short tick (4 cycles) and
// a 3-tick settle window so every commit lands 11..14 cycles after a clean edge.
module tb_switch_debouncer;

    localparam int WIDTH        = 8;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int LAT_MIN      = 2 + (STABLE_TICKS - 1) * TICK_DIV + 1;
    localparam int LAT_MAX      = 2 + STABLE_TICKS * TICK_DIV;
    localparam int WAIT_LIMIT   = 40;

    typedef struct {
        string      name;
        logic [7:0] raw;
        logic [7:0] stable;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] stable;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] swRaw;
    logic [WIDTH-1:0] swStable;
    logic [WIDTH-1:0] swRise;
    logic [WIDTH-1:0] swFall;
    logic             changed;
    logic             changedClr;

    vec_t       vecs[5];
    exp_t       expQ[$];
    int         checkCount;
    int         passCount;
    logic [7:0] curStable;

    switch_debouncer #(
        .WIDTH       (WIDTH),
        .TICK_DIV    (TICK_DIV),
        .STABLE_TICKS(STABLE_TICKS)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(reset),
        .sw_raw     (swRaw),
        .sw_stable  (swStable),
        .sw_rise    (swRise),
        .sw_fall    (swFall),
        .changed    (changed),
        .changed_clr(changedClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act === req) passCount++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic checkRange(input string name, input int val, input int lo, input int hi);
        checkCount++;
        if (val >= lo && val <= hi) passCount++;
        else $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, val, lo, hi);
    endtask

    // Counts edges until sw_stable leaves prev; strobes must stay quiet until then.
    task automatic waitCommit(input logic [7:0] prev, output int n, output bit quiet);
        n     = 0;
        quiet = 1'b1;
        while (n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
            if (swStable !== prev) break;
            if (swRise !== 8'h00 || swFall !== 8'h00) quiet = 1'b0;
        end
    endtask

    task automatic clearChanged(input string name);
        changedClr = 1'b1;
        @(negedge clk);
        changedClr = 1'b0;
        checkValue(name, {31'b0, changed}, 32'd0);
    endtask

    task automatic settle(input logic [7:0] raw, input string name);
        int n;
        bit quiet;
        swRaw = raw;
        waitCommit(curStable, n, quiet);
        checkRange({name, "_latency"}, n, LAT_MIN, LAT_MAX);
        checkValue({name, "_stable"}, {24'b0, swStable}, {24'b0, raw});
        curStable = raw;
        @(negedge clk);
        clearChanged({name, "_clr"});
    endtask

    task automatic setVec(input int idx, input string name, input logic [7:0] raw,
                          input logic [7:0] stable, input logic [7:0] rise, input logic [7:0] fall);
        vecs[idx].name   = name;
        vecs[idx].raw    = raw;
        vecs[idx].stable = stable;
        vecs[idx].rise   = rise;
        vecs[idx].fall   = fall;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.name   = v.name;
        e.stable = v.stable;
        e.rise   = v.rise;
        e.fall   = v.fall;
        swRaw    = v.raw;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        int   n;
        bit   quiet;
        waitCommit(curStable, n, quiet);
        if (expQ.size() == 0) begin
            checkValue("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        checkRange({e.name, "_latency"}, n, LAT_MIN, LAT_MAX);
        checkValue({e.name, "_quiet"}, {31'b0, quiet}, 32'd1);
        checkValue({e.name, "_stable"}, {24'b0, swStable}, {24'b0, e.stable});
        checkValue({e.name, "_rise"}, {24'b0, swRise}, {24'b0, e.rise});
        checkValue({e.name, "_fall"}, {24'b0, swFall}, {24'b0, e.fall});
        curStable = e.stable;
        @(negedge clk);
        checkValue({e.name, "_strobe_end"}, {16'b0, swRise, swFall}, 32'd0);
        checkValue({e.name, "_changed"}, {31'b0, changed}, 32'd1);
        clearChanged({e.name, "_clr"});
    endtask

    initial begin
        int  n;
        bit  quiet;
        bit  flagOk;
        int  gap;

        checkCount = 0;
        passCount  = 0;
        curStable  = 8'h00;
        reset      = 1'b1;
        changedClr = 1'b0;
        swRaw      = 8'hFF;

        setVec(0, "clr_bit3", 8'hF7, 8'hF7, 8'h00, 8'h08);
        setVec(1, "all_off",  8'h00, 8'h00, 8'h00, 8'hF7);
        setVec(2, "a5_on",    8'hA5, 8'hA5, 8'hA5, 8'h00);
        setVec(3, "swap",     8'h5A, 8'h5A, 8'h5A, 8'hA5);
        setVec(4, "all_off2", 8'h00, 8'h00, 8'h00, 8'h5A);

        // Reset with switches high, then power-up commit of every bit.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) checkValue("reset_outputs", {swStable, swRise, swFall, 7'b0, changed}, 32'd0);
        end
        reset = 1'b0;
        waitCommit(8'h00, n, quiet);
        checkRange("powerup_latency", n, LAT_MIN, LAT_MAX);
        checkValue("powerup_quiet", {31'b0, quiet}, 32'd1);
        checkValue("powerup_stable", {24'b0, swStable}, 32'hFF);
        checkValue("powerup_rise", {24'b0, swRise}, 32'hFF);
        curStable = 8'hFF;
        @(negedge clk);
        checkValue("powerup_rise_end", {24'b0, swRise}, 32'h00);
        checkValue("powerup_changed", {31'b0, changed}, 32'd1);
        clearChanged("powerup_clr");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Bounce on bit 0 every 5 cycles never survives three ticks.
        flagOk = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c % 5 == 0) swRaw[0] = ~swRaw[0];
            @(negedge clk);
            if (swStable !== 8'h00 || swRise !== 8'h00 || swFall !== 8'h00 || changed !== 1'b0) flagOk = 1'b0;
        end
        swRaw = 8'h00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (swStable !== 8'h00 || swRise !== 8'h00 || swFall !== 8'h00 || changed !== 1'b0) flagOk = 1'b0;
        end
        checkValue("bounce_quiet", {31'b0, flagOk}, 32'd1);

        // Clear requested in the very cycle a commit strobes: the set must win.
        swRaw = 8'h01;
        waitCommit(8'h00, n, quiet);
        checkValue("clrset_rise", {24'b0, swRise}, 32'h01);
        changedClr = 1'b1;
        @(negedge clk);
        changedClr = 1'b0;
        checkValue("clr_vs_set", {31'b0, changed}, 32'd1);
        @(negedge clk);
        checkValue("changed_holds", {31'b0, changed}, 32'd1);
        curStable = 8'h01;
        clearChanged("clrset_clr");
        settle(8'h00, "clrset_back");

        // Reset partway through bit 5's window discards its count.
        swRaw  = 8'h20;
        flagOk = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (swStable !== 8'h00) flagOk = 1'b0;
        end
        checkValue("midcount_no_commit", {31'b0, flagOk}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkValue("midreset_cleared", {swStable, swRise, swFall, 7'b0, changed}, 32'd0);
        waitCommit(8'h00, n, quiet);
        checkRange("midreset_window", n, LAT_MIN, LAT_MAX);
        checkValue("midreset_stable", {24'b0, swStable}, 32'h20);
        checkValue("midreset_rise", {24'b0, swRise}, 32'h20);
        curStable = 8'h20;
        @(negedge clk);
        clearChanged("midreset_clr");
        settle(8'h00, "midreset_back");

        // Bit 1 then bit 6 four cycles later: commits exactly one tick apart.
        swRaw = 8'h02;
        repeat (4) @(negedge clk);
        swRaw = 8'h42;
        waitCommit(8'h00, n, quiet);
        checkRange("bit1_latency", n + 4, LAT_MIN, LAT_MAX);
        checkValue("bit1_rise", {24'b0, swRise}, 32'h02);
        checkValue("bit1_stable", {24'b0, swStable}, 32'h02);
        gap    = 0;
        flagOk = 1'b1;
        do begin
            @(negedge clk);
            gap++;
            if (changed !== 1'b1) flagOk = 1'b0;
        end while (swRise === 8'h00 && gap < 10);
        checkValue("bit6_gap", gap, 32'd4);
        checkValue("bit6_rise", {24'b0, swRise}, 32'h40);
        checkValue("bit6_stable", {24'b0, swStable}, 32'h42);
        @(negedge clk);
        checkValue("bit6_rise_end", {24'b0, swRise}, 32'h00);
        checkValue("two_changed_held", {31'b0, flagOk & changed}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
